// File: rtl/jtag_pkg.sv
// jtag_pkg: shared TAP state encoding, instruction codes and the TMS graph
// used by jtag_tap_responder. Instruction constants are 32 bits wide and are
// sized to IR_WIDTH at the point of use.
package jtag_pkg;

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'd0,
        RUN_TEST_IDLE    = 4'd1,
        SELECT_DR        = 4'd2,
        CAPTURE_DR       = 4'd3,
        SHIFT_DR         = 4'd4,
        EXIT1_DR         = 4'd5,
        PAUSE_DR         = 4'd6,
        EXIT2_DR         = 4'd7,
        UPDATE_DR        = 4'd8,
        SELECT_IR        = 4'd9,
        CAPTURE_IR       = 4'd10,
        SHIFT_IR         = 4'd11,
        EXIT1_IR         = 4'd12,
        PAUSE_IR         = 4'd13,
        EXIT2_IR         = 4'd14,
        UPDATE_IR        = 4'd15
    } tap_state_t;

    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_USER
    } dr_sel_t;

    localparam logic [31:0] INSTR_IDCODE       = 32'd6;
    localparam logic [31:0] INSTR_USER         = 32'd2;
    localparam logic [31:0] INSTR_BYPASS       = '1;
    localparam logic [31:0] IR_CAPTURE_PATTERN = 32'd1;

    // Standard 1149.1 TMS transition graph.
    function automatic tap_state_t tap_next(tap_state_t s, logic tms);
        tap_state_t n;
        n = s;
        case (s)
            TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    n = tms ? SELECT_DR        : RUN_TEST_IDLE;
            SELECT_DR:        n = tms ? SELECT_IR        : CAPTURE_DR;
            CAPTURE_DR:       n = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         n = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         n = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         n = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         n = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        n = tms ? SELECT_DR        : RUN_TEST_IDLE;
            SELECT_IR:        n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       n = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         n = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         n = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         n = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         n = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        n = tms ? SELECT_DR        : RUN_TEST_IDLE;
            default:          n = TEST_LOGIC_RESET;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_tap_responder_if.sv
// jtag_tap_responder_if: JTAG pins plus the fabric-side user DR bridge.
// master = initiator/fabric side, slave = the TAP responder.
interface jtag_tap_responder_if #(
    parameter int IR_WIDTH   = 10,
    parameter int USER_WIDTH = 8
);
    logic                   tck;
    logic                   tms;
    logic                   tdi;
    logic                   tdo;
    logic                   tdo_en;
    jtag_pkg::tap_state_t   tap_state;
    logic [IR_WIDTH-1:0]    ir_value;
    logic [USER_WIDTH-1:0]  user_capture_data;
    logic [USER_WIDTH-1:0]  user_update_data;
    logic                   user_update_valid;

    modport master (
        output tck, tms, tdi, user_capture_data,
        input  tdo, tdo_en, tap_state, ir_value, user_update_data, user_update_valid
    );

    modport slave (
        input  tck, tms, tdi, user_capture_data,
        output tdo, tdo_en, tap_state, ir_value, user_update_data, user_update_valid
    );
endinterface

// File: rtl/jtag_pin_sync.sv
// jtag_pin_sync: 2-flop synchronizer plus one delay flop for tck/tms/tdi.
// Edge strobes are registered so they line up with the delayed tms/tdi.
module jtag_pin_sync (
    input  logic clk,
    input  logic rst,
    input  logic tck,
    input  logic tms,
    input  logic tdi,
    output logic tck_rise,
    output logic tck_fall,
    output logic tms_s,
    output logic tdi_s
);
    // [0],[1] synchronizer, [2] delay stage
    logic [2:0] tck_p;
    logic [2:0] tms_p;
    logic [2:0] tdi_p;

    // Shift the pins through the pipeline and strobe tck edges at the delay stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            tck_p    <= '0;
            tms_p    <= '0;
            tdi_p    <= '0;
            tck_rise <= 1'b0;
            tck_fall <= 1'b0;
        end else begin
            tck_p    <= {tck_p[1:0], tck};
            tms_p    <= {tms_p[1:0], tms};
            tdi_p    <= {tdi_p[1:0], tdi};
            tck_rise <= tck_p[1] & ~tck_p[2];
            tck_fall <= ~tck_p[1] & tck_p[2];
        end
    end

    assign tms_s = tms_p[2];
    assign tdi_s = tdi_p[2];
endmodule

// File: rtl/jtag_tap_responder.sv
// jtag_tap_responder: oversampled IEEE 1149.1 TAP target with IR, IDCODE,
// BYPASS and an optional user DR. Define JTAG_TAP_USER_DR_EN to build the
// user DR; otherwise USER decodes to BYPASS and the user outputs are 0.
module jtag_tap_responder
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH     = 10,
    parameter logic [31:0] IDCODE_VALUE = 32'h1234_5679,
    parameter int          USER_WIDTH   = 8
) (
    input logic                 clk,
    input logic                 rst,
    jtag_tap_responder_if.slave jtag
);
    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(INSTR_IDCODE);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(IR_CAPTURE_PATTERN);

    logic                tck_rise;
    logic                tck_fall;
    logic                tms_s;
    logic                tdi_s;
    tap_state_t          state_q;
    tap_state_t          state_d;
    logic [IR_WIDTH-1:0] ir_shift_q;
    logic [IR_WIDTH-1:0] ir_value_q;
    logic [31:0]         idcode_shift_q;
    logic                bypass_q;
    logic                user_lsb;
    dr_sel_t             dr_sel;
    logic                dr_lsb;
    logic                tdo_q;

    jtag_pin_sync u_pin_sync (
        .clk      (clk),
        .rst      (rst),
        .tck      (jtag.tck),
        .tms      (jtag.tms),
        .tdi      (jtag.tdi),
        .tck_rise (tck_rise),
        .tck_fall (tck_fall),
        .tms_s    (tms_s),
        .tdi_s    (tdi_s)
    );

    // TAP state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= TEST_LOGIC_RESET;
        else     state_q <= state_d;
    end

    // Next state: follow the TMS graph on each synchronized tck rise.
    always_comb begin
        state_d = state_q;
        if (tck_rise) state_d = tap_next(state_q, tms_s);
    end

    // Instruction shift register and latched instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_shift_q <= '0;
            ir_value_q <= IR_IDCODE;
        end else begin
            if (tck_rise) begin
                case (state_q)
                    CAPTURE_IR: ir_shift_q <= IR_CAPTURE;
                    SHIFT_IR:   ir_shift_q <= {tdi_s, ir_shift_q[IR_WIDTH-1:1]};
                    UPDATE_IR:  ir_value_q <= ir_shift_q;
                    default: ;
                endcase
            end
            if (state_q == TEST_LOGIC_RESET) ir_value_q <= IR_IDCODE;
        end
    end

    // Decode the active data register from the latched instruction.
    always_comb begin
        dr_sel = DR_BYPASS;
        if (ir_value_q == IR_IDCODE) dr_sel = DR_IDCODE;
`ifdef JTAG_TAP_USER_DR_EN
        else if (ir_value_q == IR_WIDTH'(INSTR_USER)) dr_sel = DR_USER;
`endif
    end

    // IDCODE and BYPASS have no side effects, so they capture/shift regardless of selection.
    always_ff @(posedge clk) begin
        if (rst) begin
            idcode_shift_q <= '0;
            bypass_q       <= 1'b0;
        end else if (tck_rise) begin
            case (state_q)
                CAPTURE_DR: begin
                    idcode_shift_q <= IDCODE_VALUE;
                    bypass_q       <= 1'b0;
                end
                SHIFT_DR: begin
                    idcode_shift_q <= {tdi_s, idcode_shift_q[31:1]};
                    bypass_q       <= tdi_s;
                end
                default: ;
            endcase
        end
    end

`ifdef JTAG_TAP_USER_DR_EN
    logic [USER_WIDTH-1:0] user_shift_q;
    logic [USER_WIDTH-1:0] user_update_q;
    logic                  user_valid_q;

    // User DR: capture from fabric, shift, and publish with a one-cycle strobe on update.
    always_ff @(posedge clk) begin
        if (rst) begin
            user_shift_q  <= '0;
            user_update_q <= '0;
            user_valid_q  <= 1'b0;
        end else begin
            user_valid_q <= 1'b0;
            if (tck_rise && dr_sel == DR_USER) begin
                case (state_q)
                    CAPTURE_DR: user_shift_q <= jtag.user_capture_data;
                    SHIFT_DR:   user_shift_q <= {tdi_s, user_shift_q[USER_WIDTH-1:1]};
                    UPDATE_DR: begin
                        user_update_q <= user_shift_q;
                        user_valid_q  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign user_lsb               = user_shift_q[0];
    assign jtag.user_update_data  = user_update_q;
    assign jtag.user_update_valid = user_valid_q;
`else
    logic unused_user_capture;
    assign unused_user_capture    = ^jtag.user_capture_data;
    assign user_lsb               = 1'b0;
    assign jtag.user_update_data  = '0;
    assign jtag.user_update_valid = 1'b0;
`endif

    // Serial output bit of the selected data register.
    always_comb begin
        dr_lsb = bypass_q;
        case (dr_sel)
            DR_IDCODE: dr_lsb = idcode_shift_q[0];
            DR_USER:   dr_lsb = user_lsb;
            default: ;
        endcase
    end

    // TDO is re-launched on tck fall and holds outside the shift states.
    always_ff @(posedge clk) begin
        if (rst) begin
            tdo_q <= 1'b0;
        end else if (tck_fall) begin
            if (state_q == SHIFT_IR)      tdo_q <= ir_shift_q[0];
            else if (state_q == SHIFT_DR) tdo_q <= dr_lsb;
        end
    end

    assign jtag.tdo       = tdo_q;
    assign jtag.tdo_en    = (state_q == SHIFT_IR) || (state_q == SHIFT_DR);
    assign jtag.tap_state = state_q;
    assign jtag.ir_value  = ir_value_q;
endmodule

// File: tb/tb_jtag_tap_responder.sv
// tb_jtag_tap_responder: directed JTAG sessions against a queue-based model
// of the TAP; works with or without JTAG_TAP_USER_DR_EN defined.
`timescale 1ns/1ps
module tb_jtag_tap_responder;
    import jtag_pkg::*;

    localparam int HALF = 6;  // clk cycles per tck half-period
`ifdef JTAG_TAP_USER_DR_EN
    localparam bit USER_EN = 1'b1;
`else
    localparam bit USER_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jtag_tap_responder_if #(.IR_WIDTH(10), .USER_WIDTH(8)) bus ();

    jtag_tap_responder #(
        .IR_WIDTH     (10),
        .IDCODE_VALUE (32'h1234_5679),
        .USER_WIDTH   (8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .jtag (bus)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    logic check_en    = 1'b0;

    // model state
    tap_state_t graph [16][2];
    tap_state_t m_state;
    logic [9:0] m_ir;
    logic       irq [$];
    logic       drq [$];
    logic       m_tdo;
    logic [7:0] m_upd;
    int         m_pulses    = 0;
    int         seen_pulses = 0;
    int         pulse_len   = 0;
    logic       last_tdo;

    initial begin
        graph[TEST_LOGIC_RESET] = '{RUN_TEST_IDLE, TEST_LOGIC_RESET};
        graph[RUN_TEST_IDLE]    = '{RUN_TEST_IDLE, SELECT_DR};
        graph[SELECT_DR]        = '{CAPTURE_DR,    SELECT_IR};
        graph[CAPTURE_DR]       = '{SHIFT_DR,      EXIT1_DR};
        graph[SHIFT_DR]         = '{SHIFT_DR,      EXIT1_DR};
        graph[EXIT1_DR]         = '{PAUSE_DR,      UPDATE_DR};
        graph[PAUSE_DR]         = '{PAUSE_DR,      EXIT2_DR};
        graph[EXIT2_DR]         = '{SHIFT_DR,      UPDATE_DR};
        graph[UPDATE_DR]        = '{RUN_TEST_IDLE, SELECT_DR};
        graph[SELECT_IR]        = '{CAPTURE_IR,    TEST_LOGIC_RESET};
        graph[CAPTURE_IR]       = '{SHIFT_IR,      EXIT1_IR};
        graph[SHIFT_IR]         = '{SHIFT_IR,      EXIT1_IR};
        graph[EXIT1_IR]         = '{PAUSE_IR,      UPDATE_IR};
        graph[PAUSE_IR]         = '{PAUSE_IR,      EXIT2_IR};
        graph[EXIT2_IR]         = '{SHIFT_IR,      UPDATE_IR};
        graph[UPDATE_IR]        = '{RUN_TEST_IDLE, SELECT_DR};
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = TEST_LOGIC_RESET;
        m_ir    = 10'h006;
        m_tdo   = 1'b0;
        m_upd   = 8'h00;
        irq.delete();
        drq.delete();
    endtask

    // Action of the state being left, then the TMS move.
    task automatic model_rise(input logic m, input logic d);
        logic [31:0] idv;
        logic [7:0]  cap;
        idv = 32'h1234_5679;
        cap = bus.user_capture_data;
        case (m_state)
            CAPTURE_IR: begin
                irq.delete();
                irq.push_back(1'b1);
                for (int i = 1; i < 10; i++) irq.push_back(1'b0);
            end
            SHIFT_IR: begin
                void'(irq.pop_front());
                irq.push_back(d);
            end
            UPDATE_IR: for (int i = 0; i < 10; i++) m_ir[i] = irq[i];
            CAPTURE_DR: begin
                drq.delete();
                if (m_ir == 10'h006)
                    for (int i = 0; i < 32; i++) drq.push_back(idv[i]);
                else if (USER_EN && m_ir == 10'h002)
                    for (int i = 0; i < 8; i++) drq.push_back(cap[i]);
                else
                    drq.push_back(1'b0);
            end
            SHIFT_DR: begin
                void'(drq.pop_front());
                drq.push_back(d);
            end
            UPDATE_DR: begin
                if (USER_EN && m_ir == 10'h002) begin
                    for (int i = 0; i < 8; i++) m_upd[i] = drq[i];
                    m_pulses++;
                end
            end
            default: ;
        endcase
        m_state = graph[m_state][m];
        if (m_state == TEST_LOGIC_RESET) m_ir = 10'h006;
    endtask

    task automatic model_fall();
        if (m_state == SHIFT_IR)      m_tdo = irq[0];
        else if (m_state == SHIFT_DR) m_tdo = drq[0];
    endtask

    // Per-cycle comparison once the DUT has had time to absorb the last tck edge.
    always @(negedge clk) begin
        if (bus.user_update_valid) begin
            pulse_len++;
            if (pulse_len == 1) seen_pulses++;
        end else begin
            if (pulse_len != 0) cmp("valid_width", 32'(pulse_len), 32'd1);
            pulse_len = 0;
        end
        if (check_en) begin
            cmp("tap_state", 32'(bus.tap_state), 32'(m_state));
            cmp("ir_value", 32'(bus.ir_value), 32'(m_ir));
            cmp("tdo_en", 32'(bus.tdo_en), 32'(m_state == SHIFT_IR || m_state == SHIFT_DR));
            cmp("tdo", 32'(bus.tdo), 32'(m_tdo));
            cmp("user_update_data", 32'(bus.user_update_data), 32'(m_upd));
            cmp("pulse_count", 32'(seen_pulses), 32'(m_pulses));
        end
    end

    task automatic step(input logic m, input logic d);
        bus.tms = m;
        bus.tdi = d;
        repeat (HALF) @(posedge clk);
        #1;
        bus.tck  = 1'b1;
        check_en = 1'b0;
        model_rise(m, d);
        repeat (HALF - 1) @(posedge clk);
        #1 check_en = 1'b1;
        @(posedge clk);
        #1;
        bus.tck  = 1'b0;
        check_en = 1'b0;
        model_fall();
        repeat (HALF - 1) @(posedge clk);
        #1 check_en = 1'b1;
        @(negedge clk);
        last_tdo = bus.tdo;
    endtask

    task automatic shift_ir(input logic [9:0] val, output logic [9:0] out);
        out = '0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            out[i] = last_tdo;
            step(i == 9, val[i]);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic shift_dr(input int n, input logic [31:0] val, output logic [31:0] out);
        out = '0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            out[i] = last_tdo;
            step(i == n - 1, val[i]);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic do_reset(input int cycles);
        check_en = 1'b0;
        rst      = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_en = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] o32;
        logic [9:0]  o10;
        int          p0;
        bus.tck = 1'b0;
        bus.tms = 1'b0;
        bus.tdi = 1'b0;
        bus.user_capture_data = 8'h00;
        rst = 1'b1;

        do_reset(4);
        cmp("reset_state", 32'(bus.tap_state), 32'(TEST_LOGIC_RESET));
        cmp("reset_ir", 32'(bus.ir_value), 32'h006);
        cmp("reset_tdo", 32'(bus.tdo), 32'd0);

        repeat (5) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        cmp("idle_state", 32'(bus.tap_state), 32'(RUN_TEST_IDLE));

        shift_dr(32, 32'h0, o32);
        cmp("idcode_out", o32, 32'h1234_5679);

        shift_ir(10'h3FF, o10);
        cmp("ir_capture_out", 32'(o10), 32'h001);
        cmp("ir_bypass", 32'(bus.ir_value), 32'h3FF);
        shift_dr(8, 32'hA5, o32);
        cmp("bypass_a5", o32, 32'h4A);

        bus.user_capture_data = 8'h3C;
        p0 = seen_pulses;
        shift_ir(10'h002, o10);
        shift_dr(8, 32'hC3, o32);
        cmp("user_out", o32, USER_EN ? 32'h3C : 32'h86);
        cmp("user_update", 32'(bus.user_update_data), USER_EN ? 32'hC3 : 32'h00);
        cmp("user_pulses", 32'(seen_pulses - p0), USER_EN ? 32'd1 : 32'd0);

        shift_ir(10'h155, o10);
        cmp("ir_155", 32'(bus.ir_value), 32'h155);
        shift_dr(8, 32'hFF, o32);
        cmp("unknown_bypass", o32, 32'hFE);

        bus.user_capture_data = 8'h5A;
        shift_ir(10'h002, o10);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        p0 = seen_pulses;
        do_reset(3);
        cmp("midrst_state", 32'(bus.tap_state), 32'(TEST_LOGIC_RESET));
        cmp("midrst_ir", 32'(bus.ir_value), 32'h006);
        cmp("midrst_update", 32'(bus.user_update_data), 32'h00);
        step(1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        cmp("midrst_no_pulse", 32'(seen_pulses - p0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
